instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: pc register, imem request FSM, one-entry output buffer.
// Optional transfer counter on fetch_count when IFETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    FLUSH
  } state_t;

  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_ipc;

  logic        w_held;
  logic        w_fetch_req;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic        w_load;
  logic        w_xfer;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  // An issued request is held in WAIT and FLUSH until acked.
  assign w_held      = (r_state == WAIT) || (r_state == FLUSH);
  assign w_fetch_req = (!r_valid || instr_ready) && !redirect;
  assign w_req       = (r_state == FETCH) ? w_fetch_req : w_held;
  assign w_addr      = w_held ? r_req_addr : r_pc;
  assign w_ack       = imem_ack && w_req;
  assign w_xfer      = r_valid && instr_ready;
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc    = w_addr + 32'd4;
  assign w_unused    = ^redirect_pc[1:0];

  // Acked data is kept only in FETCH/WAIT and only without a redirect.
  assign w_load = w_ack && !redirect &&
                  ((r_state == FETCH) || (r_state == WAIT));

  assign imem_req    = w_req;
  assign imem_addr   = w_addr;
  assign instr_valid = r_valid;
  assign instruction = r_instr;
  assign instr_pc    = r_ipc;

  // Request FSM; latches the address of a request left outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req_addr <= PC0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (w_req && !w_ack) begin
            r_state    <= WAIT;
            r_req_addr <= r_pc;
          end
        end
        WAIT: begin
          if (w_ack)
            r_state <= FETCH;
          else if (redirect)
            r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_ack)
            r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect wins, otherwise advance past each kept word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= PC0;
    else if (redirect)
      r_pc <= w_redir_pc;
    else if (w_load)
      r_pc <= w_pc_inc;
  end

  // Output buffer data: captured only on a kept ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'd0;
      r_ipc   <= 32'd0;
    end else if (w_load) begin
      r_instr <= imem_rdata;
      r_ipc   <= w_addr;
    end
  end

  // Output buffer valid: redirect drops it, load sets it, transfer clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_valid <= 1'b0;
    else if (redirect)
      r_valid <= 1'b0;
    else if (w_load)
      r_valid <= 1'b1;
    else if (w_xfer)
      r_valid <= 1'b0;
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  assign fetch_count = r_fetch_count;

  // Counts decode transfers; discarded words never become valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fetch_count <= 32'd0;
    else if (w_xfer)
      r_fetch_count <= r_fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vector table
// plus hand sequences for asynchronous reset and the transfer counter.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instruction_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] dat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
  } vec_t;

  int n_chk;
  int n_pass;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic ack,
                       input logic [31:0] dat);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = dat;
  endtask

  vec_t tv[27];

  function automatic vec_t mk(input logic rdy, input logic rd,
                              input logic [31:0] rpc, input logic ack,
                              input logic [31:0] dat, input logic e_req,
                              input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_ins,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.ack = ack; v.dat = dat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_ins = e_ins; v.e_ipc = e_ipc;
    return v;
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;
    //        rdy rd rpc           ack dat           req addr          vld ins           ipc
    tv[0]  = mk(1, 0, 32'h0,        1, 32'h00000013, 1, 32'h00000000, 0, 32'h0,        32'h0);
    tv[1]  = mk(1, 0, 32'h0,        1, 32'h11111111, 1, 32'h00000004, 1, 32'h00000013, 32'h0);
    tv[2]  = mk(1, 0, 32'h0,        1, 32'h22222222, 1, 32'h00000008, 1, 32'h11111111, 32'h4);
    tv[3]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0000000C, 1, 32'h22222222, 32'h8);
    tv[4]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0000000C, 0, 32'h22222222, 32'h8);
    tv[5]  = mk(1, 0, 32'h0,        1, 32'h8C220004, 1, 32'h0000000C, 0, 32'h22222222, 32'h8);
    tv[6]  = mk(1, 0, 32'h0,        1, 32'hB0B0B0B0, 1, 32'h00000010, 1, 32'h8C220004, 32'hC);
    tv[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000014, 1, 32'hB0B0B0B0, 32'h10);
    tv[8]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000014, 1, 32'hB0B0B0B0, 32'h10);
    tv[9]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000014, 1, 32'hB0B0B0B0, 32'h10);
    tv[10] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000014, 1, 32'hB0B0B0B0, 32'h10);
    tv[11] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h00000014, 1, 32'hB0B0B0B0, 32'h10);
    tv[12] = mk(1, 0, 32'h0,        1, 32'hB1B1B1B1, 1, 32'h00000014, 0, 32'hB0B0B0B0, 32'h10);
    tv[13] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h00000018, 1, 32'hB1B1B1B1, 32'h14);
    tv[14] = mk(1, 1, 32'h00000103, 0, 32'h0,        1, 32'h00000018, 0, 32'hB1B1B1B1, 32'h14);
    tv[15] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h00000018, 0, 32'hB1B1B1B1, 32'h14);
    tv[16] = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 1, 32'h00000018, 0, 32'hB1B1B1B1, 32'h14);
    tv[17] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h00000100, 0, 32'hB1B1B1B1, 32'h14);
    tv[18] = mk(1, 0, 32'h0,        1, 32'hC0C0C0C0, 1, 32'h00000100, 0, 32'hB1B1B1B1, 32'h14);
    tv[19] = mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h00000104, 1, 32'hC0C0C0C0, 32'h100);
    tv[20] = mk(1, 0, 32'h0,        1, 32'hD0D0D0D0, 1, 32'hFFFFFFFC, 0, 32'hC0C0C0C0, 32'h100);
    tv[21] = mk(1, 0, 32'h0,        1, 32'hD1D1D1D1, 1, 32'h00000000, 1, 32'hD0D0D0D0, 32'hFFFFFFFC);
    tv[22] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000004, 1, 32'hD1D1D1D1, 32'h0);
    tv[23] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h00000004, 1, 32'hD1D1D1D1, 32'h0);
    tv[24] = mk(1, 1, 32'h00000200, 1, 32'hBADBAD00, 1, 32'h00000004, 0, 32'hD1D1D1D1, 32'h0);
    tv[25] = mk(1, 0, 32'h0,        1, 32'hE0E0E0E0, 1, 32'h00000200, 0, 32'hD1D1D1D1, 32'h0);
    tv[26] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000204, 1, 32'hE0E0E0E0, 32'h200);

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    #3;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction,          32'h0);
    chk("rst_ipc",   instr_pc,             32'h0);
    #4;
    rst_n = 1'b1;
    #3;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      drive(tv[i].rdy, tv[i].rd, tv[i].rpc, tv[i].ack, tv[i].dat);
      #4;
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, tv[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,            tv[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, tv[i].e_vld});
      chk($sformatf("v%0d_instr", i), instruction,          tv[i].e_ins);
      chk($sformatf("v%0d_ipc", i),   instr_pc,             tv[i].e_ipc);
    end

    // Reset while a request is outstanding in WAIT.
    @(posedge clk);
    #1;
    drive(1, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    chk("wait_addr", imem_addr, 32'h00000204);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, imem_req},    32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr",  imem_addr,            32'h0);
    chk("arst_instr", instruction,          32'h0);
    chk("arst_ipc",   instr_pc,             32'h0);
    drive(1, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // Restart: six immediate acks give five decode transfers.
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 32'h0, 1, 32'hA000_0000 + k);
      #4;
      chk($sformatf("rs%0d_addr", k), imem_addr, 32'(k * 4));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    #4;
    chk("rs_valid", {31'd0, instr_valid}, 32'd1);
    chk("rs_instr", instruction, 32'hA0000005);
    chk("rs_ipc",   instr_pc,    32'h00000014);
`ifdef IFETCH_PERF_CNT_EN
    chk("cnt_five", fetch_count, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", fetch_count, 32'd0);
    rst_n = 1'b1;
`endif
    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
